// File: rtl/doodle_jump_ctrl.sv
// Game-side controller for the doodle jump core: launches jumps, tracks absolute
// height, detects landings on higher platforms, keeps score and declares game over.
module doodle_jump_ctrl #(
    parameter logic [7:0] JUMP_H  = 8'd40,
    parameter int         TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        Game_Start,
    input  logic        q_I,
    input  logic        q_Up,
    input  logic        q_Down,
    input  logic        q_Done,
    input  logic [7:0]  Curr,
    input  logic        Plat_Valid,
    input  logic [9:0]  Plat_Y,
    input  logic        Floor_Valid,
    output logic        Start,
    output logic        Ack,
    output logic [7:0]  Jin,
    output logic        Core_Rst,
    output logic [9:0]  Y_pos,
    output logic [15:0] Score,
    output logic        Game_Over,
    output logic        Fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_AIR, S_LAND, S_ACK, S_RESYNC, S_OVER
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tmo_q;
    logic [9:0]    base_q;
    logic [9:0]    plat_q;
    logic [15:0]   score_q;
    logic          fault_q;

    logic [3:0]    q_vec;
    logic          one_hot;
    logic          tmo_hit;
    logic [10:0]   y_sum;
    logic          land_hit;
    logic [9:0]    climb;
    logic [16:0]   score_sum;

    assign q_vec   = {q_Done, q_Down, q_Up, q_I};
    assign one_hot = $onehot(q_vec);
    assign tmo_hit = (tmo_q == CW'(TIMEOUT - 1));
    assign y_sum   = {1'b0, base_q} + {3'b000, Curr};

    // The match uses the unsaturated sum so a wrapped height can never alias a platform.
    assign land_hit = q_Down && one_hot && Plat_Valid &&
                      (Plat_Y > base_q) && (y_sum == {1'b0, Plat_Y});

    assign climb     = plat_q - base_q;
    assign score_sum = {1'b0, score_q} + {7'd0, climb};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (Game_Start) state_d = S_LAUNCH;
            S_LAUNCH: begin
                if (q_Up)         state_d = S_AIR;
                else if (tmo_hit) state_d = S_RESYNC;
            end
            S_AIR: begin
                if (!one_hot)     state_d = S_RESYNC;
                else if (land_hit) state_d = S_LAND;
                else if (q_Done)  state_d = S_ACK;
            end
            S_LAND:   state_d = S_LAUNCH;
            S_ACK: begin
                if (q_I)          state_d = Floor_Valid ? S_LAUNCH : S_OVER;
                else if (tmo_hit) state_d = S_RESYNC;
            end
            S_RESYNC: state_d = S_LAUNCH;
            S_OVER:   if (Game_Start) state_d = S_LAUNCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                tmo_q <= '0;
            else if (tmo_q != CW'(TIMEOUT))
                tmo_q <= tmo_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            base_q  <= '0;
            plat_q  <= '0;
            score_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (Game_Start) begin
                        base_q  <= '0;
                        score_q <= '0;
                        fault_q <= 1'b0;
                    end
                end
                S_AIR:    if (land_hit) plat_q <= Plat_Y;
                S_LAND: begin
                    base_q  <= plat_q;
                    score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                end
                S_RESYNC: fault_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign Start     = (state_q == S_LAUNCH);
    assign Ack       = (state_q == S_ACK);
    assign Jin       = JUMP_H;
    assign Core_Rst  = reset || (state_q == S_LAND) || (state_q == S_RESYNC);
    assign Y_pos     = y_sum[10] ? 10'd1023 : y_sum[9:0];
    assign Score     = score_q;
    assign Game_Over = (state_q == S_OVER);
    assign Fault     = fault_q;

endmodule

// File: tb/tb_doodle_jump_ctrl.sv
// Directed bench for doodle_jump_ctrl: the core is driven by hand, expectations are hand-computed.
module tb_doodle_jump_ctrl;

    logic        Clk = 1'b0;
    logic        reset;
    logic        Game_Start;
    logic [3:0]  qv;
    logic [7:0]  Curr;
    logic        Plat_Valid;
    logic [9:0]  Plat_Y;
    logic        Floor_Valid;
    logic        Start, Ack, Core_Rst, Game_Over, Fault;
    logic [7:0]  Jin;
    logic [9:0]  Y_pos;
    logic [15:0] Score;

    int errs   = 0;
    int checks = 0;
    int n_start;

    localparam logic [3:0] QI = 4'b0001, QU = 4'b0010, QD = 4'b0100, QN = 4'b1000;

    doodle_jump_ctrl #(.JUMP_H(8'd8), .TIMEOUT(16)) dut (
        .Clk(Clk), .reset(reset), .Game_Start(Game_Start),
        .q_I(qv[0]), .q_Up(qv[1]), .q_Down(qv[2]), .q_Done(qv[3]),
        .Curr(Curr), .Plat_Valid(Plat_Valid), .Plat_Y(Plat_Y), .Floor_Valid(Floor_Valid),
        .Start(Start), .Ack(Ack), .Jin(Jin), .Core_Rst(Core_Rst), .Y_pos(Y_pos),
        .Score(Score), .Game_Over(Game_Over), .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; Game_Start = 1'b0; qv = QI; Curr = 8'd0;
        Plat_Valid = 1'b0; Plat_Y = 10'd0; Floor_Valid = 1'b1;
        step(); step();
        chk("rst_core_rst", Core_Rst, 1);
        chk("rst_start", Start, 0);
        chk("rst_ack", Ack, 0);
        chk("rst_over", Game_Over, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_score", Score, 0);
        chk("jin", Jin, 8'd8);
        reset = 1'b0;
        step();
        chk("idle_start", Start, 0);
        chk("idle_core_rst", Core_Rst, 0);

        // 1: plain jump, no platforms
        Game_Start = 1'b1; step(); Game_Start = 1'b0;
        chk("t1_start", Start, 1);
        step(); step();
        chk("t1_start_hold", Start, 1);
        qv = QU; step();
        chk("t1_start_drop", Start, 0);
        for (int c = 1; c <= 8; c++) begin Curr = 8'(c); step(); end
        chk("t1_peak", Y_pos, 10'd8);
        qv = QD;
        for (int c = 7; c >= 0; c--) begin Curr = 8'(c); step(); end
        chk("t1_floor", Y_pos, 10'd0);
        qv = QN; step();
        chk("t1_ack", Ack, 1);
        step(); step();
        chk("t1_ack_hold", Ack, 1);
        qv = QI; step();
        chk("t1_ack_drop", Ack, 0);
        chk("t1_relaunch", Start, 1);
        chk("t1_score", Score, 0);

        // 2: landing on a platform at 5 during the descent
        qv = QU; step();
        for (int c = 1; c <= 8; c++) begin Curr = 8'(c); step(); end
        qv = QD; Plat_Valid = 1'b1; Plat_Y = 10'd5;
        Curr = 8'd7; step();
        Curr = 8'd6; step();
        chk("t2_no_early_land", Core_Rst, 0);
        Curr = 8'd5; step();
        chk("t2_land_pulse", Core_Rst, 1);
        Plat_Valid = 1'b0; qv = QI; Curr = 8'd0;
        step();
        chk("t2_pulse_1cyc", Core_Rst, 0);
        chk("t2_score", Score, 5);
        chk("t2_relaunch", Start, 1);
        chk("t2_base", Y_pos, 10'd5);
        qv = QU; step();
        Curr = 8'd8; #1;
        chk("t2_peak", Y_pos, 10'd13);

        // 3: matches during the ascent or at Plat_Y == Base are ignored
        Plat_Valid = 1'b1; Plat_Y = 10'd13; step();
        chk("t3_up_ignored", Core_Rst, 0);
        qv = QD; Curr = 8'd0; Plat_Y = 10'd5; step();
        chk("t3_base_ignored", Core_Rst, 0);
        Plat_Valid = 1'b0;
        qv = QN; step();
        chk("t3_ack", Ack, 1);
        chk("t3_score", Score, 5);

        // 4: floor gone when the core returns idle
        Floor_Valid = 1'b0; qv = QI; step();
        chk("t4_over", Game_Over, 1);
        chk("t4_no_start", Start, 0);
        step();
        chk("t4_over_hold", Game_Over, 1);
        Floor_Valid = 1'b1; Game_Start = 1'b1; step(); Game_Start = 1'b0;
        chk("t4_over_clr", Game_Over, 0);
        chk("t4_score_clr", Score, 0);
        chk("t4_base_clr", Y_pos, 10'd0);
        chk("t4_restart", Start, 1);

        // 5: core never reaches q_Up -> timeout resync
        n_start = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Start) n_start++;
            else break;
        end
        chk("t5_start_cycles", n_start, 16);
        chk("t5_resync_pulse", Core_Rst, 1);
        step();
        chk("t5_fault", Fault, 1);
        chk("t5_pulse_end", Core_Rst, 0);
        chk("t5_relaunch", Start, 1);
        Game_Start = 1'b1; step(); Game_Start = 1'b0;
        chk("t5_gs_ignored", Fault, 1);

        // all-zero core state in AIR -> resync
        qv = QU; step();
        qv = 4'b0000; step();
        chk("t6_zero_resync", Core_Rst, 1);
        qv = QI; step();
        chk("t6_relaunch", Start, 1);

        // 6a: score saturation with a preloaded score and a landing at 200
        qv = QU; step();
        force dut.score_q = 16'hFFF0;
        step();
        release dut.score_q;
        qv = QD; Curr = 8'd200; Plat_Valid = 1'b1; Plat_Y = 10'd200; step();
        chk("t6_land", Core_Rst, 1);
        Plat_Valid = 1'b0; qv = QI; Curr = 8'd0; step();
        chk("t6_score_sat", Score, 16'hFFFF);
        chk("t6_base", Y_pos, 10'd200);

        // 6b: asynchronous reset mid-air
        qv = QU; step();
        Curr = 8'd3; step();
        #2 reset = 1'b1; #1;
        chk("t6_rst_core", Core_Rst, 1);
        chk("t6_rst_start", Start, 0);
        chk("t6_rst_score", Score, 0);
        chk("t6_rst_fault", Fault, 0);
        chk("t6_rst_base", Y_pos, 10'd3);
        step();
        reset = 1'b0; qv = QI; Curr = 8'd0;
        step();
        chk("t6_idle", Start, 0);
        chk("t6_idle_rst", Core_Rst, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
